// File: rtl/sensor_link_pkg.sv
// rtl/sensor_link_pkg.sv - shared types and constants for the sensor link scheduler
package sensor_link_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND    = 3'd1,
        WAIT_TX = 3'd2,
        RX_HI   = 3'd3,
        RX_LO   = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam int RESP_W = 16;

    localparam logic [7:0] CMD_TEMP   = 8'h01;
    localparam logic [7:0] CMD_HUMID  = 8'h02;
    localparam logic [7:0] CMD_STATUS = 8'h03;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first asserted req at or after rr_ptr
module rr_pick #(
    parameter int N_REQ = 4,
    localparam int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] sel,
    output logic [PTR_W-1:0] sel_idx,
    output logic             any
);

    int cand;

    always_comb begin
        sel     = '0;
        sel_idx = '0;
        any     = 1'b0;
        cand    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!any && req[cand]) begin
                any       = 1'b1;
                sel[cand] = 1'b1;
                sel_idx   = PTR_W'(cand);
            end
        end
    end

endmodule

// File: rtl/sensor_link_scheduler.sv
// rtl/sensor_link_scheduler.sv - round-robin owner of the UART sensor link: one command out, two reply bytes back
module sensor_link_scheduler
    import sensor_link_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 500000,
    parameter int TO_W           = 20
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [8*N_REQ-1:0]  req_cmd,
    output logic [N_REQ-1:0]    grant,
    output logic                resp_valid,
    output logic                resp_tmo,
    output logic [RESP_W-1:0]   resp_data,
    output logic                tx_start,
    output logic [7:0]          tx_byte,
    input  logic                tx_done,
    input  logic                rx_dv,
    input  logic [7:0]          rx_byte
);

    localparam int PTR_W = $clog2(N_REQ);

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [N_REQ-1:0]   pick_sel;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;
    logic [TO_W-1:0]    to_cnt;
    logic               to_hit;
    logic [7:0]         resp_hi;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .sel     (pick_sel),
        .sel_idx (pick_idx),
        .any     (pick_any)
    );

    assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Pulses are Moore/Mealy outputs of the current state so a reset clears them asynchronously.
    always_comb begin
        state_nxt  = state;
        tx_start   = 1'b0;
        resp_valid = 1'b0;
        resp_tmo   = 1'b0;
        case (state)
            IDLE:    if (pick_any) state_nxt = SEND;
            SEND: begin
                tx_start  = 1'b1;
                state_nxt = WAIT_TX;
            end
            WAIT_TX: if (tx_done) state_nxt = RX_HI;
            RX_HI: begin
                if (rx_dv) begin
                    state_nxt = RX_LO;
                end else if (to_hit) begin
                    resp_tmo  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RX_LO: begin
                if (rx_dv) begin
                    state_nxt = DONE;
                end else if (to_hit) begin
                    resp_tmo  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            tx_byte   <= '0;
            to_cnt    <= '0;
            resp_hi   <= '0;
            resp_data <= '0;
        end else begin
            state <= state_nxt;
            // Counter spans both reply bytes; it is zero in WAIT_TX, so tx_done starts it from 0.
            if (state == RX_HI || state == RX_LO) begin
                to_cnt <= to_cnt + TO_W'(1);
            end else begin
                to_cnt <= '0;
            end
            if (state == IDLE && pick_any) begin
                grant   <= pick_sel;
                tx_byte <= req_cmd[8*pick_idx +: 8];
                rr_ptr  <= (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
            end else if (state_nxt == IDLE) begin
                grant <= '0;
            end
            if (state == RX_HI && rx_dv) begin
                resp_hi <= rx_byte;
            end
            // Load at the RX_LO exit so resp_data is already valid during the DONE pulse.
            if (state == RX_LO && rx_dv) begin
                resp_data <= {resp_hi, rx_byte};
            end
        end
    end

endmodule

// File: tb/tb_sensor_link_scheduler.sv
// tb/tb_sensor_link_scheduler.sv - self-checking bench for sensor_link_scheduler
module tb_sensor_link_scheduler;
    import sensor_link_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 100;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  req = '0;
    logic [8*N-1:0] req_cmd = '0;
    logic [N-1:0]  grant;
    logic          resp_valid, resp_tmo, tx_start;
    logic [15:0]   resp_data;
    logic [7:0]    tx_byte;
    logic          tx_done = 1'b0;
    logic          rx_dv = 1'b0;
    logic [7:0]    rx_byte = '0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [N-1:0] grant;
        logic [7:0]   cmd;
        logic [15:0]  data;
        logic         tmo;
    } exp_t;
    exp_t sb[$];

    sensor_link_scheduler #(.N_REQ(N), .TIMEOUT_CYCLES(TMO), .TO_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .req_cmd    (req_cmd),
        .grant      (grant),
        .resp_valid (resp_valid),
        .resp_tmo   (resp_tmo),
        .resp_data  (resp_data),
        .tx_start   (tx_start),
        .tx_byte    (tx_byte),
        .tx_done    (tx_done),
        .rx_dv      (rx_dv),
        .rx_byte    (rx_byte)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic [N-1:0] g, input logic [7:0] c, input logic [15:0] d, input logic t);
        exp_t e;
        e.grant = g; e.cmd = c; e.data = d; e.tmo = t;
        sb.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        rx_dv = 1'b1; rx_byte = b;
        tick();
        rx_dv = 1'b0;
    endtask

    // Waits for tx_start, plays the UART side, then checks the response against the scoreboard.
    task automatic run_txn(input int nbytes, input logic [7:0] hi, input logic [7:0] lo,
                           input bit stray, input bit drop);
        exp_t e;
        bit   seen;
        int   k;
        seen = 0;
        k = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (tx_start === 1'b1) seen = 1;
        end
        n_vec++;
        if (!seen || sb.size() == 0) begin
            n_err++;
            $display("FAIL tx_start_wait: seen=%0d queued=%0d", seen, sb.size());
            return;
        end
        e = sb.pop_front();
        n_vec++;
        if (tx_byte !== e.cmd) begin
            n_err++; $display("FAIL tx_byte: got %h want %h", tx_byte, e.cmd);
        end
        n_vec++;
        if (grant !== e.grant) begin
            n_err++; $display("FAIL grant_at_send: got %b want %b", grant, e.grant);
        end
        @(negedge clock);
        n_vec++;
        if (tx_start !== 1'b0) begin
            n_err++; $display("FAIL tx_start_width: got %b want 0", tx_start);
        end
        if (stray) begin
            tick();
            rx_dv = 1'b1; rx_byte = 8'hFF;
            tick();
            rx_dv = 1'b0;
        end
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        if (nbytes >= 1) send_byte(hi);
        if (nbytes >= 2) send_byte(lo);
        seen = 0;
        for (int i = 0; i < TMO + 40 && !seen; i++) begin
            @(negedge clock);
            if (resp_valid === 1'b1 || resp_tmo === 1'b1) begin
                seen = 1;
                k = i + 1;
            end
        end
        n_vec++;
        if (!seen) begin
            n_err++; $display("FAIL resp_wait: no resp_valid/resp_tmo within budget");
            return;
        end
        n_vec++;
        if (resp_valid !== !e.tmo || resp_tmo !== e.tmo) begin
            n_err++;
            $display("FAIL resp_kind: got valid=%b tmo=%b want valid=%b tmo=%b",
                     resp_valid, resp_tmo, !e.tmo, e.tmo);
        end
        n_vec++;
        if (resp_data !== e.data) begin
            n_err++; $display("FAIL resp_data: got %h want %h", resp_data, e.data);
        end
        n_vec++;
        if (grant !== e.grant) begin
            n_err++; $display("FAIL grant_at_resp: got %b want %b", grant, e.grant);
        end
        if (e.tmo && nbytes == 0) begin
            n_vec++;
            if (k != TMO) begin
                n_err++; $display("FAIL tmo_latency: got %0d cycles want %0d", k, TMO);
            end
        end
        tick();
        if (drop) req = '0;
        @(negedge clock);
        n_vec++;
        if (grant !== '0 || resp_valid !== 1'b0 || resp_tmo !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_resp: got grant=%b valid=%b tmo=%b want 0/0/0",
                     grant, resp_valid, resp_tmo);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        req = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if (grant !== '0 || resp_valid !== 1'b0 || resp_tmo !== 1'b0 || resp_data !== '0 ||
            tx_start !== 1'b0 || tx_byte !== '0) begin
            n_err++;
            $display("FAIL reset_values: got grant=%b v=%b t=%b d=%h s=%b b=%h want all 0",
                     grant, resp_valid, resp_tmo, resp_data, tx_start, tx_byte);
        end
        apply_reset();
    endtask

    task automatic test_single();
        req_cmd = {8'h44, CMD_STATUS, CMD_HUMID, CMD_TEMP};
        req = 4'b0001;
        push_exp(4'b0001, CMD_TEMP, 16'h1A2B, 1'b0);
        run_txn(2, 8'h1A, 8'h2B, 0, 1);
    endtask

    task automatic test_round_robin();
        logic [7:0] hi;
        logic [7:0] lo;
        apply_reset();
        req_cmd = {8'h44, CMD_STATUS, CMD_HUMID, CMD_TEMP};
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            hi = 8'hC0 + 8'(i);
            lo = 8'(i);
            push_exp(4'b0001 << (i % N), req_cmd[8*(i%N) +: 8], {hi, lo}, 1'b0);
            run_txn(2, hi, lo, 0, i == 4);
        end
    endtask

    task automatic test_timeout();
        req = 4'b0010;
        push_exp(4'b0010, CMD_HUMID, 16'hC404, 1'b1);
        run_txn(0, 8'h00, 8'h00, 0, 1);
    endtask

    task automatic test_partial();
        req = 4'b0100;
        push_exp(4'b0100, CMD_STATUS, 16'hC404, 1'b1);
        run_txn(1, 8'h55, 8'h00, 0, 1);
    endtask

    task automatic test_stray_rx();
        tick();
        rx_dv = 1'b1; rx_byte = 8'hFF;
        tick();
        rx_dv = 1'b0;
        tick();
        req = 4'b0001;
        push_exp(4'b0001, CMD_TEMP, 16'h0007, 1'b0);
        run_txn(2, 8'h00, 8'h07, 1, 1);
    endtask

    task automatic test_reset_mid_rx();
        bit seen;
        seen = 0;
        req = 4'b1000;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (tx_start === 1'b1) seen = 1;
        end
        n_vec++;
        if (!seen || grant !== 4'b1000) begin
            n_err++; $display("FAIL pre_reset_grant: got %b want 1000", grant);
        end
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        send_byte(8'h99);
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if (grant !== '0 || resp_valid !== 1'b0 || resp_tmo !== 1'b0 || resp_data !== '0 ||
            tx_start !== 1'b0 || tx_byte !== '0) begin
            n_err++;
            $display("FAIL async_reset: got grant=%b v=%b t=%b d=%h s=%b b=%h want all 0",
                     grant, resp_valid, resp_tmo, resp_data, tx_start, tx_byte);
        end
        req = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            n_vec++;
            if (resp_valid !== 1'b0 || resp_tmo !== 1'b0 || grant !== '0) begin
                n_err++;
                $display("FAIL reset_hold: got v=%b t=%b grant=%b want 0", resp_valid, resp_tmo, grant);
            end
        end
        tick();
        reset = 1'b1;
        req = 4'b0100;
        push_exp(4'b0100, CMD_STATUS, 16'h1234, 1'b0);
        run_txn(2, 8'h12, 8'h34, 0, 1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_partial();
        test_stray_rx();
        test_reset_mid_rx();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
